// File: rtl/cpu_debug_core.sv
// UART-controlled single-step R-type core (ADD/SUB/MUL/DIV) with an on-chip debugger.
// Define CPU_UART_ECHO_EN to retransmit every correctly received byte on tx.
module cpu_debug_core #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned IMEM_AW      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic tx,
    output logic CPU_clk,
    output logic CPU_reset
);
    localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [31:0] CMD_RST1 = 32'h3154_5352;
    localparam logic [31:0] CMD_RST0 = 32'h3054_5352;
    localparam logic [31:0] CMD_IMEN = 32'h6E45_4D49;
    localparam logic [31:0] CMD_CCLK = 32'h6B6C_6363;
    localparam logic [31:0] CMD_ZERO = 32'h3030_3030;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t           rx_state_q, rx_state_d;
    logic                rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0]       rx_cnt_q, rx_cnt_d;
    logic [2:0]          rx_bit_q, rx_bit_d;
    logic [7:0]          rx_shift_q, rx_shift_d;
    logic                byte_valid_q, byte_valid_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         word_q, word_d;
    logic [31:0]         word;
    logic                word_valid;
    logic                cpu_reset_q, cpu_reset_d;
    logic                cpu_clk_q, cpu_clk_d, cpu_clk_prev_q;
    logic                prog_mode_q, prog_mode_d;
    logic                slot_q, slot_d;
    logic [IMEM_AW-1:0]  addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [IMEM_AW-1:0]  pc_q, pc_d;
    logic [31:0]         regs_q [32];
    logic [31:0]         regs_d [32];
    logic [31:0]         imem_q [1 << IMEM_AW];
    logic                step, imem_we;
    logic [31:0]         instr, rs_val, rt_val, alu;
    logic                alu_en;
    logic                unused_shamt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d     = '0;
                    rx_state_d   = RX_IDLE;
                    byte_valid_d = rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Word is presented combinationally in the 4th byte's valid cycle; command state registers it.
    always_comb begin
        word       = {rx_shift_q, word_q[31:8]};
        word_valid = byte_valid_q && (byte_cnt_q == 2'd3);
        word_d     = byte_valid_q ? word : word_q;
        byte_cnt_d = byte_valid_q ? byte_cnt_q + 2'd1 : byte_cnt_q;

        cpu_reset_d = cpu_reset_q;
        cpu_clk_d   = cpu_clk_q;
        prog_mode_d = prog_mode_q;
        slot_d      = slot_q;
        addr_d      = addr_q;
        data_d      = data_q;
        if (word_valid) begin
            case (word)
                CMD_RST1: cpu_reset_d = 1'b1;
                CMD_RST0: cpu_reset_d = 1'b0;
                CMD_IMEN: begin
                    prog_mode_d = !prog_mode_q;
                    slot_d      = 1'b0;
                end
                CMD_CCLK: cpu_clk_d = 1'b1;
                CMD_ZERO: cpu_clk_d = 1'b0;
                default: begin
                    if (prog_mode_q) begin
                        if (!slot_q) addr_d = word[IMEM_AW-1:0];
                        else         data_d = word;
                        slot_d = !slot_q;
                    end
                end
            endcase
        end
    end

    always_comb begin
        step         = cpu_clk_q && !cpu_clk_prev_q;
        imem_we      = step && prog_mode_q;
        instr        = imem_q[pc_q];
        unused_shamt = ^instr[10:6];
        rs_val       = (instr[25:21] == 5'd0) ? '0 : regs_q[instr[25:21]];
        rt_val       = (instr[20:16] == 5'd0) ? '0 : regs_q[instr[20:16]];
        alu_en       = 1'b1;
        case (instr[5:0])
            6'd4:    alu = rs_val + rt_val;
            6'd5:    alu = rs_val - rt_val;
            6'd6:    alu = rs_val * rt_val;
            6'd7:    alu = (rt_val == '0) ? '1 : rs_val / rt_val;
            default: begin
                alu    = '0;
                alu_en = 1'b0;
            end
        endcase

        regs_d = regs_q;
        pc_d   = pc_q;
        if (cpu_reset_q) begin
            pc_d = '0;
            for (int unsigned i = 0; i < 32; i++) regs_d[i] = 32'(i);
        end else if (step && !prog_mode_q) begin
            if (instr[31:26] == 6'd0 && alu_en && instr[15:11] != 5'd0)
                regs_d[instr[15:11]] = alu;
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q     <= RX_IDLE;
            rx_cnt_q       <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            byte_valid_q   <= 1'b0;
            byte_cnt_q     <= '0;
            word_q         <= '0;
            cpu_reset_q    <= 1'b1;
            cpu_clk_q      <= 1'b0;
            cpu_clk_prev_q <= 1'b0;
            prog_mode_q    <= 1'b0;
            slot_q         <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            pc_q           <= '0;
            for (int unsigned i = 0; i < 32; i++) regs_q[i] <= 32'(i);
        end else begin
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_bit_q       <= rx_bit_d;
            rx_shift_q     <= rx_shift_d;
            byte_valid_q   <= byte_valid_d;
            byte_cnt_q     <= byte_cnt_d;
            word_q         <= word_d;
            cpu_reset_q    <= cpu_reset_d;
            cpu_clk_q      <= cpu_clk_d;
            cpu_clk_prev_q <= cpu_clk_q;
            prog_mode_q    <= prog_mode_d;
            slot_q         <= slot_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            pc_q           <= pc_d;
            regs_q         <= regs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (imem_we) imem_q[addr_q] <= data_q;
    end

    assign CPU_clk   = cpu_clk_q;
    assign CPU_reset = cpu_reset_q;

`ifdef CPU_UART_ECHO_EN
    logic          tx_busy_q, tx_busy_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bits_q, tx_bits_d;
    logic [9:0]    tx_shift_q, tx_shift_d;

    // Frame is {stop, data, start}, shifted out LSB first; a byte arriving mid-frame is not echoed.
    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bits_d  = tx_bits_q;
        tx_shift_d = tx_shift_q;
        if (!tx_busy_q) begin
            if (byte_valid_q) begin
                tx_shift_d = {1'b1, rx_shift_q, 1'b0};
                tx_bits_d  = 4'd9;
                tx_cnt_d   = '0;
                tx_busy_d  = 1'b1;
            end
        end else if (tx_cnt_q == BIT_END) begin
            tx_cnt_d   = '0;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            if (tx_bits_q == 4'd0) tx_busy_d = 1'b0;
            else                   tx_bits_d = tx_bits_q - 4'd1;
        end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end
        tx = tx_busy_q ? tx_shift_q[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bits_q  <= '0;
            tx_shift_q <= '1;
        end else begin
            tx_busy_q  <= tx_busy_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bits_q  <= tx_bits_d;
            tx_shift_q <= tx_shift_d;
        end
    end
`else
    always_comb tx = 1'b1;
`endif

endmodule

// File: tb/tb_cpu_debug_core.sv
// Scoreboard bench for cpu_debug_core: words are issued over rx, expected debugger outputs are queued and checked by a monitor.
module tb_cpu_debug_core;
    localparam int CPB = 16;

    localparam logic [31:0] RST1 = 32'h3154_5352;
    localparam logic [31:0] RST0 = 32'h3054_5352;
    localparam logic [31:0] IMEN = 32'h6E45_4D49;
    localparam logic [31:0] CCLK = 32'h6B6C_6363;
    localparam logic [31:0] ZERO = 32'h3030_3030;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx = 1'b1;
    logic tx, CPU_clk, CPU_reset;

    typedef struct {
        logic       rst;
        logic       cclk;
        logic [5:0] pc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] echo_q[$];
    int         checks = 0;
    int         fails = 0;
    int         tx_low = 0;

    cpu_debug_core #(.CLKS_PER_BIT(CPB), .IMEM_AW(6)) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx), .CPU_clk(CPU_clk), .CPU_reset(CPU_reset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic good_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(good_stop);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input logic e_rst, input logic e_clk, input logic [5:0] e_pc);
        exp_t e;
        e.rst = e_rst; e.cclk = e_clk; e.pc = e_pc;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            echo_q.push_back(w[8*i +: 8]);
            send_byte(w[8*i +: 8], 1'b1);
        end
    endtask

    // Output monitor: every assembled word must have a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && dut.word_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_word: got word %h, expected none", dut.word);
                end else begin
                    e = exp_q.pop_front();
                    @(negedge clk);
                    chk("cpu_reset", {31'd0, CPU_reset}, {31'd0, e.rst});
                    chk("cpu_clk", {31'd0, CPU_clk}, {31'd0, e.cclk});
                    @(negedge clk);
                    chk("pc", {26'd0, dut.pc_q}, {26'd0, e.pc});
                end
            end
        end
    end

`ifdef CPU_UART_ECHO_EN
    initial begin
        logic [7:0] b;
        logic [7:0] eb;
        forever begin
            @(negedge clk);
            if (reset && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                chk("echo_stop", {31'd0, tx}, 32'd1);
                if (echo_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL echo_extra: got byte %h, expected none", b);
                end else begin
                    eb = echo_q.pop_front();
                    chk("echo_byte", {24'd0, b}, {24'd0, eb});
                end
            end
        end
    end
`else
    initial forever begin
        @(negedge clk);
        if (tx !== 1'b1) tx_low++;
    end
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prog [6];
        prog[0] = 32'h0043_0804; prog[1] = 32'h0043_2005;
        prog[2] = 32'h0043_2806; prog[3] = 32'h0043_3007;
        prog[4] = 32'h0040_3807; prog[5] = 32'h0043_4020;

        repeat (5) @(posedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_cpu_reset", {31'd0, CPU_reset}, 32'd1);
        chk("rst_cpu_clk", {31'd0, CPU_clk}, 32'd0);
        chk("rst_pc", {26'd0, dut.pc_q}, 32'd0);
        chk("rst_r7", dut.regs_q[7], 32'd7);
        @(posedge clk);

        send_word(RST1, 1'b1, 1'b0, 6'd0);
        send_word(RST0, 1'b0, 1'b0, 6'd0);

        send_word(IMEN, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 4; i++) begin
            send_word(32'(i), 1'b0, 1'b0, 6'd0);
            send_word(prog[i], 1'b0, 1'b0, 6'd0);
            send_word(CCLK, 1'b0, 1'b1, 6'd0);
            send_word(ZERO, 1'b0, 1'b0, 6'd0);
        end
        send_word(IMEN, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 4; i++) chk("imem", dut.imem_q[i], prog[i]);

        for (int i = 0; i < 4; i++) begin
            send_word(CCLK, 1'b0, 1'b1, 6'(i + 1));
            send_word(ZERO, 1'b0, 1'b0, 6'(i + 1));
        end
        chk("add_r1", dut.regs_q[1], 32'd5);
        chk("sub_r4", dut.regs_q[4], 32'hFFFF_FFFF);
        chk("mul_r5", dut.regs_q[5], 32'd6);
        chk("div_r6", dut.regs_q[6], 32'd0);

        send_word(IMEN, 1'b0, 1'b0, 6'd4);
        for (int i = 4; i < 6; i++) begin
            send_word(32'(i), 1'b0, 1'b0, 6'd4);
            send_word(prog[i], 1'b0, 1'b0, 6'd4);
            send_word(CCLK, 1'b0, 1'b1, 6'd4);
            send_word(ZERO, 1'b0, 1'b0, 6'd4);
        end
        send_word(IMEN, 1'b0, 1'b0, 6'd4);
        send_word(CCLK, 1'b0, 1'b1, 6'd5);
        send_word(CCLK, 1'b0, 1'b1, 6'd5);
        send_word(ZERO, 1'b0, 1'b0, 6'd5);
        send_word(CCLK, 1'b0, 1'b1, 6'd6);
        send_word(ZERO, 1'b0, 1'b0, 6'd6);
        chk("div0_r7", dut.regs_q[7], 32'hFFFF_FFFF);
        chk("nop_r8", dut.regs_q[8], 32'd8);
        chk("keep_r1", dut.regs_q[1], 32'd5);

        send_word(RST1, 1'b1, 1'b0, 6'd0);
        chk("rst1_r1", dut.regs_q[1], 32'd1);
        send_word(CCLK, 1'b1, 1'b1, 6'd0);
        send_word(ZERO, 1'b1, 1'b0, 6'd0);
        chk("held_r7", dut.regs_q[7], 32'd7);

        send_byte(8'hA5, 1'b0);
        send_word(RST0, 1'b0, 1'b0, 6'd0);

        echo_q.push_back(8'h52);
        send_byte(8'h52, 1'b1);
        echo_q.push_back(8'h53);
        send_byte(8'h53, 1'b1);
        repeat (12 * CPB) @(posedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_cpu_reset", {31'd0, CPU_reset}, 32'd1);
        @(posedge clk);
        send_word(RST0, 1'b0, 1'b0, 6'd0);

        repeat (12 * CPB) @(posedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);
`ifdef CPU_UART_ECHO_EN
        chk("echo_drained", echo_q.size(), 32'd0);
`else
        chk("tx_idle", tx_low, 32'd0);
`endif
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
